// File: rtl/ram_dp_clr_if.sv
// Port bundle for ram_dp_clr: write port, read port and the ready/valid status.
// The bench or host logic takes the master side and the RAM takes the slave side.
interface ram_dp_clr_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ready;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, ready
    );
endinterface

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (1W/1R) that zero-fills every word after reset before going live.
// Optional macro RAM_BYPASS_EN: same-address read+write returns the new word (write-first).
module ram_dp_clr #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    ram_dp_clr_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;

    assign wr_fire = (state == ST_READY) && bus.wr_en;
    assign rd_fire = (state == ST_READY) && bus.rd_en;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // The clear engine owns the write port until the last word is zeroed.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        mem_we       = 1'b0;
        mem_waddr    = bus.wr_addr;
        mem_wdata    = bus.wr_data;
        case (state)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                mem_waddr    = clr_addr;
                mem_wdata    = '0;
                clr_addr_nxt = clr_addr + 1'b1;
                if (&clr_addr)
                    state_nxt = ST_READY;
            end
            ST_READY: begin
                mem_we = wr_fire;
            end
        endcase
    end

    // Writes are suppressed on reset edges so a reset from READY cannot land a user write.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we && !reset)
            mem[mem_waddr] <= mem_wdata;
    end

`ifdef RAM_BYPASS_EN
    assign rd_word = (wr_fire && (bus.wr_addr == bus.rd_addr)) ? bus.wr_data
                                                                : mem[bus.rd_addr];
`else
    assign rd_word = mem[bus.rd_addr];
`endif

    // Stage p1: registered read data and its valid strobe
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= rd_fire;
            if (rd_fire)
                rd_data_p1 <= rd_word;
        end
    end

    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_valid = vld_p1;
    assign bus.ready    = (state == ST_READY);
endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the RAM.
module tb_ram_dp_clr;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
`ifdef RAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    ram_dp_clr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_dp_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model: the memory is an array that is all zero after any reset,
    // ports go live DEPTH clean cycles after reset, reads return one cycle later.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_cyc;
    logic              m_ready;
    logic              exp_vld;
    logic [DATA_W-1:0] exp_data;

    always @(posedge CLOCK_50) begin
        if (reset) begin
            m_cyc    <= 0;
            m_ready  <= 1'b0;
            exp_vld  <= 1'b0;
            exp_data <= '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc == DEPTH - 1) m_ready <= 1'b1;
            exp_vld <= m_ready && bus.rd_en;
            if (m_ready && bus.rd_en)
                exp_data <= (BYP && bus.wr_en && bus.wr_addr == bus.rd_addr)
                            ? bus.wr_data : m_mem[bus.rd_addr];
            if (m_ready && bus.wr_en) m_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            n_chk = n_chk + 3;
            if (bus.ready !== m_ready) begin
                n_fail = n_fail + 1;
                $display("FAIL model_ready t=%0t: got %0b expected %0b", $time, bus.ready, m_ready);
            end
            if (bus.rd_valid !== exp_vld) begin
                n_fail = n_fail + 1;
                $display("FAIL model_rd_valid t=%0t: got %0b expected %0b", $time, bus.rd_valid, exp_vld);
            end
            if (bus.rd_data !== exp_data) begin
                n_fail = n_fail + 1;
                $display("FAIL model_rd_data t=%0t: got %0h expected %0h", $time, bus.rd_data, exp_data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        bus.rd_en = 1'b0;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        bus.rd_en = 1'b1; bus.rd_addr = a;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic rand_cycle();
        bus.wr_en   = 1'($urandom_range(0, 1));
        bus.rd_en   = 1'($urandom_range(0, 1));
        bus.wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        bus.wr_data = DATA_W'($urandom);
        bus.rd_addr = ($urandom_range(0, 3) == 0) ? bus.wr_addr
                                                  : ADDR_W'($urandom_range(0, DEPTH - 1));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_ready", bus.ready, 0);
        chk("reset_rd_valid", bus.rd_valid, 0);
        chk("reset_rd_data", bus.rd_data, 0);

        // Clear pass with writes/reads attempted at the last word the whole time.
        reset = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 5'h1F; bus.wr_data = 4'hF;
        bus.rd_en = 1'b1; bus.rd_addr = 5'h1F;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            if (k == DEPTH - 1) chk("clear_ready_low_31", bus.ready, 0);
            if (k == 16) chk("clear_rd_valid_low", bus.rd_valid, 0);
        end
        chk("clear_ready_high_32", bus.ready, 1);
        chk("clear_rd_valid_stays_0", bus.rd_valid, 0);
        idle();

        for (int a = 0; a < DEPTH; a++) begin
            rd(ADDR_W'(a));
            chk("zero_fill_valid", bus.rd_valid, 1);
            chk("zero_fill_data", bus.rd_data, 0);
        end

        // Back-to-back reads of two freshly written words.
        wr(5'h01, 4'hC);
        wr(5'h03, 4'h8);
        bus.rd_en = 1'b1; bus.rd_addr = 5'h01;
        tick();
        chk("b2b_first_data", bus.rd_data, 4'hC);
        chk("b2b_first_valid", bus.rd_valid, 1);
        bus.rd_addr = 5'h03;
        tick();
        chk("b2b_second_data", bus.rd_data, 4'h8);
        chk("b2b_second_valid", bus.rd_valid, 1);
        idle();

        // Same-address collision.
        wr(5'h07, 4'h3);
        bus.wr_en = 1'b1; bus.wr_addr = 5'h07; bus.wr_data = 4'hA;
        bus.rd_en = 1'b1; bus.rd_addr = 5'h07;
        tick();
        chk("collision_data", bus.rd_data, BYP ? 4'hA : 4'h3);
        bus.wr_en = 1'b0;
        tick();
        chk("collision_reread", bus.rd_data, 4'hA);
        idle();

        // Single read pulse, then the data must hold.
        wr(5'h02, 4'h9);
        rd(5'h02);
        chk("pulse_valid_high", bus.rd_valid, 1);
        chk("pulse_data", bus.rd_data, 4'h9);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pulse_valid_low", bus.rd_valid, 0);
            chk("pulse_data_hold", bus.rd_data, 4'h9);
        end

        for (int k = 0; k < 400; k++) rand_cycle();
        idle();

        // Reset while READY, again mid-clear, then confirm contents re-zeroed.
        wr(5'h10, 4'h5);
        rd(5'h10);
        chk("pre_reset_data", bus.rd_data, 4'h5);
        reset = 1'b1;
        tick();
        chk("reset_ready_drop", bus.ready, 0);
        chk("reset_data_clear", bus.rd_data, 0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) rand_cycle();
        reset = 1'b1;
        tick();
        chk("midclear_reset_ready", bus.ready, 0);
        reset = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            rand_cycle();
            if (k == DEPTH - 1) chk("restart_ready_low_31", bus.ready, 0);
        end
        chk("restart_ready_high", bus.ready, 1);
        idle();
        rd(5'h10);
        chk("restart_read_10", bus.rd_data, 0);
        chk("restart_read_10_valid", bus.rd_valid, 1);

        for (int k = 0; k < 300; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            rand_cycle();
        end
        reset = 1'b0;
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
